dispatcher: RTL and testbench
=============================

Name: dispatcher

Overview:
- Issue stage between instruction fetch and the ROB / reservation station / load-store buffer.
- Each cycle it decodes at most one RV32I instruction and resolves its source operands from three places: the register file, ROB lookup, and same-cycle ALU/LSB broadcasts.
- It allocates a ROB slot, then issues the instruction with registered outputs to the RS (ALU ops) or the LSB (loads/stores).

Parameters:
- ROB_POS_W, 4: ROB index width. Operand tag width is ROB_POS_W+1; tag MSB=1 means pending, tag 0 means value valid.

Ports:
- clk in 1: clock
- rst in 1: reset, synchronous, active-high
- rdy in 1: global enable; when low, all state holds
- rollback in 1: flush
- inst_rdy in 1: fetch presents an instruction
- inst in 32: instruction word
- inst_pc in 32: instruction PC
- inst_pred_jump in 1: branch prediction from fetch
- inst_ack out 1: combinational; instruction consumed this cycle
- rob_nxt_full, rs_nxt_full, lsb_nxt_full in 1 each: downstream full next cycle
- rob_free_pos in ROB_POS_W: ROB slot allocated to the next issue
- reg_rs1_pos, reg_rs2_pos out 5: combinational, inst[19:15] and inst[24:20]
- reg_rs1_val, reg_rs2_val in 32: register file values
- reg_rs1_rob_id, reg_rs2_rob_id in ROB_POS_W+1: register file rename tags
- rob_rs1_pos, rob_rs2_pos out ROB_POS_W: combinational, the low bits of the matching reg tag
- rob_rs1_ready, rob_rs2_ready in 1: ROB entry already holds a result
- rob_rs1_val, rob_rs2_val in 32: ROB entry result value
- alu_result in 1, alu_result_rob_pos in ROB_POS_W, alu_result_val in 32: ALU broadcast
- lsb_result in 1, lsb_result_rob_pos in ROB_POS_W, lsb_result_val in 32: LSB broadcast
- issue out 1: ROB allocation and register-file rename strobe
- rs_en out 1: write to the reservation station
- lsb_en out 1: write to the load-store buffer
- Registered payload, all out:
  - issue_rob_pos ROB_POS_W
  - issue_opcode 7
  - issue_funct3 3
  - issue_funct7 1
  - issue_rs1_val 32, issue_rs1_rob_id ROB_POS_W+1
  - issue_rs2_val 32, issue_rs2_rob_id ROB_POS_W+1
  - issue_imm 32
  - issue_rd 5
  - issue_pc 32
  - issue_pred_jump 1

Behaviour:
- Reset (rst) and rollback:
  - issue, rs_en, lsb_en go to 0 at the next edge.
  - inst_ack is 0 during a rollback cycle.
  - Payload registers are cleared to 0 on rst only.
- rdy low: all registers hold and inst_ack=0.
- Accept condition: inst_ack = rdy & !rst & !rollback & inst_rdy & !(rob_nxt_full | rs_nxt_full | lsb_nxt_full).
- The enables are one-cycle pulses. The payload is registered at the accepting edge, so latency is 1 cycle.
- Routing:
  - Opcodes 0000011 (load) and 0100011 (store) set lsb_en.
  - Opcodes LUI, AUIPC, JAL, JALR, BRANCH, OP-IMM, OP set rs_en.
  - issue=1 for every routed instruction.
  - Any other opcode is acked and dropped: no enable asserts.
- Immediates, sign-extended:
  - I: load, JALR, OP-IMM
  - S: store
  - B: branch
  - U: LUI/AUIPC, value inst[31:12]<<12
  - J: JAL
  - OP: imm=0
- funct7 bit:
  - OP: inst[30].
  - OP-IMM with funct3=101: inst[30].
  - Otherwise 0. ADDI with imm bit 10 set must not become SUB.
- issue_rd = inst[11:7] for every instruction. Stores and branches still drive the field; the ROB ignores it.
- Operand resolution, per source, in priority order:
  1. Register index 0, or source unused: value 0, tag 0. rs1 is unused for LUI/AUIPC/JAL. rs2 is unused for LUI/AUIPC/JAL/JALR/load/OP-IMM.
  2. reg tag MSB=0: register file value, tag 0.
  3. alu_result and alu_result_rob_pos == tag[ROB_POS_W-1:0]: ALU value, tag 0.
  4. lsb_result with matching pos: LSB value, tag 0.
  5. rob_*_ready: ROB value, tag 0.
  6. Else: pass the tag (MSB=1), value 0.
- Simultaneous ALU and LSB match on the same pos cannot occur. If it does, ALU wins.
- The register file reflects all previously issued renames at lookup time. Back-to-back dependent instructions therefore see the producer's tag. The producer's result arriving in the consumer's issue cycle is caught by steps 3–4.
- issue_rob_pos = rob_free_pos sampled at accept.

Test Plan:
- Reset, then `addi x1,x0,5` (0x00500093) at pc 0x0:
  - Next cycle: issue=1, rs_en=1, lsb_en=0, issue_imm=5, rs1_rob_id=0, rs1_val=0, rd=1.
  - The cycle after: all enables 0.
- `add x3,x1,x2`, x1 tag 5'b1_0010 pending with ROB not ready, alu_result=1 pos 2 val 0x11 in the same cycle: rs1_val=0x11, rs1_rob_id=0. x2 tag 5'b1_0111 not ready: rs2_rob_id=5'b1_0111.
- `sw x2,8(x1)` with regs valid (x1=0x100, x2=0xAB): lsb_en=1, rs_en=0, imm=8, rs2_val=0xAB.
- rs_nxt_full=1 with inst_rdy=1: inst_ack=0, no enables. Deassert full: instruction issues next cycle.
- `addi x1,x0,0x400` (imm bit 10 set): funct7=0. `srai x1,x1,3`: funct7=1. `sub`: funct7=1.
- rollback asserted while inst_rdy=1: inst_ack=0, enables 0 next cycle. The following cycle the instruction issues normally.

Source files
------------

// File: rtl/dispatcher.sv
// Issue stage: decodes one RV32I instruction per cycle, resolves operands
// from regfile/ROB/broadcasts, allocates a ROB slot and issues to RS or LSB.
// Ports: clk/rst/rdy/rollback control; inst_* from fetch with inst_ack;
// reg_*/rob_* operand lookups; alu_/lsb_result broadcasts; issue/rs_en/
// lsb_en strobes with a registered issue_* payload.
module dispatcher #(
  parameter int ROB_POS_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 rollback,
  input  logic                 inst_rdy,
  input  logic [31:0]          inst,
  input  logic [31:0]          inst_pc,
  input  logic                 inst_pred_jump,
  output logic                 inst_ack,
  input  logic                 rob_nxt_full,
  input  logic                 rs_nxt_full,
  input  logic                 lsb_nxt_full,
  input  logic [ROB_POS_W-1:0] rob_free_pos,
  output logic [4:0]           reg_rs1_pos,
  output logic [4:0]           reg_rs2_pos,
  input  logic [31:0]          reg_rs1_val,
  input  logic [31:0]          reg_rs2_val,
  input  logic [ROB_POS_W:0]   reg_rs1_rob_id,
  input  logic [ROB_POS_W:0]   reg_rs2_rob_id,
  output logic [ROB_POS_W-1:0] rob_rs1_pos,
  output logic [ROB_POS_W-1:0] rob_rs2_pos,
  input  logic                 rob_rs1_ready,
  input  logic                 rob_rs2_ready,
  input  logic [31:0]          rob_rs1_val,
  input  logic [31:0]          rob_rs2_val,
  input  logic                 alu_result,
  input  logic [ROB_POS_W-1:0] alu_result_rob_pos,
  input  logic [31:0]          alu_result_val,
  input  logic                 lsb_result,
  input  logic [ROB_POS_W-1:0] lsb_result_rob_pos,
  input  logic [31:0]          lsb_result_val,
  output logic                 issue,
  output logic                 rs_en,
  output logic                 lsb_en,
  output logic [ROB_POS_W-1:0] issue_rob_pos,
  output logic [6:0]           issue_opcode,
  output logic [2:0]           issue_funct3,
  output logic                 issue_funct7,
  output logic [31:0]          issue_rs1_val,
  output logic [ROB_POS_W:0]   issue_rs1_rob_id,
  output logic [31:0]          issue_rs2_val,
  output logic [ROB_POS_W:0]   issue_rs2_rob_id,
  output logic [31:0]          issue_imm,
  output logic [4:0]           issue_rd,
  output logic [31:0]          issue_pc,
  output logic                 issue_pred_jump
);

  localparam int TW = ROB_POS_W + 1;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  logic [6:0] op;
  logic [2:0] f3;
  logic is_lui, is_auipc, is_jal, is_jalr, is_br;
  logic is_ld, is_st, is_imm, is_reg;
  logic route_rs, route_lsb;
  logic rs1_used, rs2_used;

  assign op       = inst[6:0];
  assign f3       = inst[14:12];
  assign is_lui   = op == OP_LUI;
  assign is_auipc = op == OP_AUIPC;
  assign is_jal   = op == OP_JAL;
  assign is_jalr  = op == OP_JALR;
  assign is_br    = op == OP_BR;
  assign is_ld    = op == OP_LD;
  assign is_st    = op == OP_ST;
  assign is_imm   = op == OP_IMM;
  assign is_reg   = op == OP_REG;

  assign route_lsb = is_ld | is_st;
  assign route_rs  = is_lui | is_auipc | is_jal | is_jalr
                   | is_br | is_imm | is_reg;

  assign rs1_used = ~(is_lui | is_auipc | is_jal);
  assign rs2_used = is_br | is_st | is_reg;

  assign inst_ack = rdy & ~rst & ~rollback & inst_rdy
                  & ~(rob_nxt_full | rs_nxt_full | lsb_nxt_full);

  assign reg_rs1_pos = inst[19:15];
  assign reg_rs2_pos = inst[24:20];
  assign rob_rs1_pos = reg_rs1_rob_id[ROB_POS_W-1:0];
  assign rob_rs2_pos = reg_rs2_rob_id[ROB_POS_W-1:0];

  // Returns {tag, value}; a zero tag means the value is final.
  function automatic logic [TW+31:0] resolve(
    input logic                 used,
    input logic [4:0]           idx,
    input logic [TW-1:0]        tag,
    input logic [31:0]          rval,
    input logic                 rrdy,
    input logic [31:0]          rrval,
    input logic                 aen,
    input logic [ROB_POS_W-1:0] apos,
    input logic [31:0]          aval,
    input logic                 len,
    input logic [ROB_POS_W-1:0] lpos,
    input logic [31:0]          lval
  );
    logic [ROB_POS_W-1:0] pos;
    pos = tag[ROB_POS_W-1:0];
    if (!used || idx == 5'd0)
      resolve = '0;
    else if (!tag[TW-1])
      resolve = {{TW{1'b0}}, rval};
    else if (aen && apos == pos)
      resolve = {{TW{1'b0}}, aval};
    else if (len && lpos == pos)
      resolve = {{TW{1'b0}}, lval};
    else if (rrdy)
      resolve = {{TW{1'b0}}, rrval};
    else
      resolve = {tag, 32'd0};
  endfunction

  logic [TW+31:0] rs1_d, rs2_d;

  always_comb begin
    rs1_d = resolve(rs1_used, inst[19:15], reg_rs1_rob_id,
                    reg_rs1_val, rob_rs1_ready, rob_rs1_val,
                    alu_result, alu_result_rob_pos, alu_result_val,
                    lsb_result, lsb_result_rob_pos, lsb_result_val);
    rs2_d = resolve(rs2_used, inst[24:20], reg_rs2_rob_id,
                    reg_rs2_val, rob_rs2_ready, rob_rs2_val,
                    alu_result, alu_result_rob_pos, alu_result_val,
                    lsb_result, lsb_result_rob_pos, lsb_result_val);
  end

  logic [31:0] imm_d;

  always_comb begin
    imm_d = '0;
    unique case (1'b1)
      is_ld, is_jalr, is_imm:
        imm_d = {{20{inst[31]}}, inst[31:20]};
      is_st:
        imm_d = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      is_br:
        imm_d = {{19{inst[31]}}, inst[31], inst[7],
                 inst[30:25], inst[11:8], 1'b0};
      is_lui, is_auipc:
        imm_d = {inst[31:12], 12'd0};
      is_jal:
        imm_d = {{11{inst[31]}}, inst[31], inst[19:12],
                 inst[20], inst[30:21], 1'b0};
      default:
        imm_d = '0;
    endcase
  end

  // Only shifts-right and OP carry the alt bit; ADDI's imm[10] must not.
  logic f7_d;
  assign f7_d = (is_reg | (is_imm & f3 == 3'b101)) & inst[30];

  logic                 issue_q, rs_en_q, lsb_en_q;
  logic [ROB_POS_W-1:0] rob_pos_q;
  logic [6:0]           op_q;
  logic [2:0]           f3_q;
  logic                 f7_q;
  logic [TW+31:0]       rs1_q, rs2_q;
  logic [31:0]          imm_q, pc_q;
  logic [4:0]           rd_q;
  logic                 pj_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_q   <= 1'b0;
      rs_en_q   <= 1'b0;
      lsb_en_q  <= 1'b0;
      rob_pos_q <= '0;
      op_q      <= '0;
      f3_q      <= '0;
      f7_q      <= 1'b0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      imm_q     <= '0;
      rd_q      <= '0;
      pc_q      <= '0;
      pj_q      <= 1'b0;
    end else if (rdy) begin
      // inst_ack is already low during rollback, clearing the strobes.
      issue_q  <= inst_ack & (route_rs | route_lsb);
      rs_en_q  <= inst_ack & route_rs;
      lsb_en_q <= inst_ack & route_lsb;
      if (inst_ack) begin
        rob_pos_q <= rob_free_pos;
        op_q      <= op;
        f3_q      <= f3;
        f7_q      <= f7_d;
        rs1_q     <= rs1_d;
        rs2_q     <= rs2_d;
        imm_q     <= is_reg ? 32'd0 : imm_d;
        rd_q      <= inst[11:7];
        pc_q      <= inst_pc;
        pj_q      <= inst_pred_jump;
      end
    end
  end

  assign issue            = issue_q;
  assign rs_en            = rs_en_q;
  assign lsb_en           = lsb_en_q;
  assign issue_rob_pos    = rob_pos_q;
  assign issue_opcode     = op_q;
  assign issue_funct3     = f3_q;
  assign issue_funct7     = f7_q;
  assign issue_rs1_val    = rs1_q[31:0];
  assign issue_rs1_rob_id = rs1_q[TW+31:32];
  assign issue_rs2_val    = rs2_q[31:0];
  assign issue_rs2_rob_id = rs2_q[TW+31:32];
  assign issue_imm        = imm_q;
  assign issue_rd         = rd_q;
  assign issue_pc         = pc_q;
  assign issue_pred_jump  = pj_q;

endmodule

// File: tb/tb_dispatcher.sv
// Scoreboard bench for dispatcher: directed instructions push expected
// issue bundles; a negedge monitor pops and compares each issued bundle.
module tb_dispatcher;

  logic        clk = 1'b0;
  logic        rst, rdy, rollback;
  logic        inst_rdy;
  logic [31:0] inst, inst_pc;
  logic        inst_pred_jump, inst_ack;
  logic        rob_nxt_full, rs_nxt_full, lsb_nxt_full;
  logic [3:0]  rob_free_pos;
  logic [4:0]  reg_rs1_pos, reg_rs2_pos;
  logic [31:0] reg_rs1_val, reg_rs2_val;
  logic [4:0]  reg_rs1_rob_id, reg_rs2_rob_id;
  logic [3:0]  rob_rs1_pos, rob_rs2_pos;
  logic        rob_rs1_ready, rob_rs2_ready;
  logic [31:0] rob_rs1_val, rob_rs2_val;
  logic        alu_result;
  logic [3:0]  alu_result_rob_pos;
  logic [31:0] alu_result_val;
  logic        lsb_result;
  logic [3:0]  lsb_result_rob_pos;
  logic [31:0] lsb_result_val;
  logic        issue, rs_en, lsb_en;
  logic [3:0]  issue_rob_pos;
  logic [6:0]  issue_opcode;
  logic [2:0]  issue_funct3;
  logic        issue_funct7;
  logic [31:0] issue_rs1_val, issue_rs2_val;
  logic [4:0]  issue_rs1_rob_id, issue_rs2_rob_id;
  logic [31:0] issue_imm, issue_pc;
  logic [4:0]  issue_rd;
  logic        issue_pred_jump;

  dispatcher #(.ROB_POS_W(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .inst_rdy(inst_rdy), .inst(inst), .inst_pc(inst_pc),
    .inst_pred_jump(inst_pred_jump), .inst_ack(inst_ack),
    .rob_nxt_full(rob_nxt_full), .rs_nxt_full(rs_nxt_full),
    .lsb_nxt_full(lsb_nxt_full), .rob_free_pos(rob_free_pos),
    .reg_rs1_pos(reg_rs1_pos), .reg_rs2_pos(reg_rs2_pos),
    .reg_rs1_val(reg_rs1_val), .reg_rs2_val(reg_rs2_val),
    .reg_rs1_rob_id(reg_rs1_rob_id), .reg_rs2_rob_id(reg_rs2_rob_id),
    .rob_rs1_pos(rob_rs1_pos), .rob_rs2_pos(rob_rs2_pos),
    .rob_rs1_ready(rob_rs1_ready), .rob_rs2_ready(rob_rs2_ready),
    .rob_rs1_val(rob_rs1_val), .rob_rs2_val(rob_rs2_val),
    .alu_result(alu_result), .alu_result_rob_pos(alu_result_rob_pos),
    .alu_result_val(alu_result_val),
    .lsb_result(lsb_result), .lsb_result_rob_pos(lsb_result_rob_pos),
    .lsb_result_val(lsb_result_val),
    .issue(issue), .rs_en(rs_en), .lsb_en(lsb_en),
    .issue_rob_pos(issue_rob_pos), .issue_opcode(issue_opcode),
    .issue_funct3(issue_funct3), .issue_funct7(issue_funct7),
    .issue_rs1_val(issue_rs1_val), .issue_rs1_rob_id(issue_rs1_rob_id),
    .issue_rs2_val(issue_rs2_val), .issue_rs2_rob_id(issue_rs2_rob_id),
    .issue_imm(issue_imm), .issue_rd(issue_rd), .issue_pc(issue_pc),
    .issue_pred_jump(issue_pred_jump)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        iss;
    logic        rs;
    logic        lsb;
    logic [3:0]  rob;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] v1;
    logic [4:0]  t1;
    logic [31:0] v2;
    logic [4:0]  t2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic        pj;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  bit   started = 1'b0;
  int   nissue = 0;

  function automatic exp_t got_bundle();
    exp_t g;
    g = '{iss: issue, rs: rs_en, lsb: lsb_en, rob: issue_rob_pos,
          op: issue_opcode, f3: issue_funct3, f7: issue_funct7,
          v1: issue_rs1_val, t1: issue_rs1_rob_id,
          v2: issue_rs2_val, t2: issue_rs2_rob_id,
          imm: issue_imm, rd: issue_rd, pc: issue_pc,
          pj: issue_pred_jump};
    return g;
  endfunction

  // Monitor: any asserted strobe must match the oldest expected issue.
  always @(negedge clk) begin
    if (started && (issue || rs_en || lsb_en)) begin
      exp_t g, e;
      g = got_bundle();
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_issue got=%h", g);
      end else begin
        e = q.pop_front();
        if (g !== e) begin
          bad++;
          $display("FAIL issue#%0d got=%h exp=%h", nissue, g, e);
        end
      end
      nissue++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] g,
                     input logic [31:0] e);
    total++;
    if (g !== e) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, g, e);
    end
  endtask

  task automatic nx();
    @(negedge clk);
    rst = 0; rdy = 1; rollback = 0;
    inst_rdy = 0; inst = 32'h0; inst_pc = 32'h0; inst_pred_jump = 0;
    rob_nxt_full = 0; rs_nxt_full = 0; lsb_nxt_full = 0;
    rob_free_pos = 0;
    reg_rs1_val = 0; reg_rs2_val = 0;
    reg_rs1_rob_id = 0; reg_rs2_rob_id = 0;
    rob_rs1_ready = 0; rob_rs2_ready = 0;
    rob_rs1_val = 0; rob_rs2_val = 0;
    alu_result = 0; alu_result_rob_pos = 0; alu_result_val = 0;
    lsb_result = 0; lsb_result_rob_pos = 0; lsb_result_val = 0;
  endtask

  task automatic cyc(input string nm, input logic ack,
                     input bit push, input exp_t e);
    #1;
    chk({nm, "_ack"}, {31'd0, inst_ack}, {31'd0, ack});
    if (push) q.push_back(e);
  endtask

  exp_t e;

  initial begin
    nx();
    rst = 1;
    @(negedge clk);
    @(negedge clk);
    chk("reset_strobes", {29'd0, issue, rs_en, lsb_en}, 32'd0);
    chk("reset_imm", issue_imm, 32'd0);
    chk("reset_rd_pos", {23'd0, issue_rd, issue_rob_pos}, 32'd0);
    started = 1'b1;

    // addi x1,x0,5: x0 source ignores regfile contents
    nx();
    inst_rdy = 1; inst = 32'h00500093; inst_pc = 32'h0;
    reg_rs1_val = 32'hDEAD; reg_rs2_val = 32'hBEEF;
    e = '{iss:1, rs:1, lsb:0, rob:0, op:7'h13, f3:0, f7:0,
          v1:0, t1:0, v2:0, t2:0, imm:5, rd:1, pc:0, pj:0};
    cyc("addi5", 1, 1, e);

    nx();
    cyc("idle1", 0, 0, e);

    // add x3,x1,x2: rs1 caught from ALU broadcast, rs2 stays pending
    nx();
    inst_rdy = 1; inst = 32'h002081B3; inst_pc = 32'h4;
    rob_free_pos = 3;
    reg_rs1_rob_id = 5'b1_0010; reg_rs2_rob_id = 5'b1_0111;
    alu_result = 1; alu_result_rob_pos = 2; alu_result_val = 32'h11;
    lsb_result = 1; lsb_result_rob_pos = 2; lsb_result_val = 32'h99;
    #1;
    chk("rs1_pos", {27'd0, reg_rs1_pos}, 32'd1);
    chk("rs2_pos", {27'd0, reg_rs2_pos}, 32'd2);
    chk("rob_pos", {24'd0, rob_rs1_pos, rob_rs2_pos}, 32'h27);
    e = '{iss:1, rs:1, lsb:0, rob:3, op:7'h33, f3:0, f7:0,
          v1:32'h11, t1:0, v2:0, t2:5'b1_0111, imm:0, rd:3,
          pc:32'h4, pj:0};
    cyc("add", 1, 1, e);

    // sw x2,8(x1)
    nx();
    inst_rdy = 1; inst = 32'h0020A423; inst_pc = 32'h8;
    rob_free_pos = 4;
    reg_rs1_val = 32'h100; reg_rs2_val = 32'hAB;
    e = '{iss:1, rs:0, lsb:1, rob:4, op:7'h23, f3:2, f7:0,
          v1:32'h100, t1:0, v2:32'hAB, t2:0, imm:8, rd:8,
          pc:32'h8, pj:0};
    cyc("sw", 1, 1, e);

    // stalls: rs full then rob full, then addi x2,x0,7 issues
    nx();
    inst_rdy = 1; inst = 32'h00700113; inst_pc = 32'hC;
    rs_nxt_full = 1; rob_free_pos = 6;
    cyc("rs_full", 0, 0, e);
    nx();
    inst_rdy = 1; inst = 32'h00700113; inst_pc = 32'hC;
    rob_nxt_full = 1; rob_free_pos = 6;
    cyc("rob_full", 0, 0, e);
    nx();
    inst_rdy = 1; inst = 32'h00700113; inst_pc = 32'hC;
    rob_free_pos = 6;
    e = '{iss:1, rs:1, lsb:0, rob:6, op:7'h13, f3:0, f7:0,
          v1:0, t1:0, v2:0, t2:0, imm:7, rd:2, pc:32'hC, pj:0};
    cyc("addi7", 1, 1, e);

    // addi x1,x0,0x400: imm bit 10 must not set funct7
    nx();
    inst_rdy = 1; inst = 32'h40000093; inst_pc = 32'h10;
    rob_free_pos = 7;
    e = '{iss:1, rs:1, lsb:0, rob:7, op:7'h13, f3:0, f7:0,
          v1:0, t1:0, v2:0, t2:0, imm:32'h400, rd:1,
          pc:32'h10, pj:0};
    cyc("addi400", 1, 1, e);

    // srai x1,x1,3
    nx();
    inst_rdy = 1; inst = 32'h4030D093; inst_pc = 32'h14;
    rob_free_pos = 8; reg_rs1_val = 32'h100; reg_rs2_val = 32'h5;
    e = '{iss:1, rs:1, lsb:0, rob:8, op:7'h13, f3:5, f7:1,
          v1:32'h100, t1:0, v2:0, t2:0, imm:32'h403, rd:1,
          pc:32'h14, pj:0};
    cyc("srai", 1, 1, e);

    // sub x5,x6,x7
    nx();
    inst_rdy = 1; inst = 32'h407302B3; inst_pc = 32'h18;
    rob_free_pos = 9; reg_rs1_val = 32'h60; reg_rs2_val = 32'h70;
    e = '{iss:1, rs:1, lsb:0, rob:9, op:7'h33, f3:0, f7:1,
          v1:32'h60, t1:0, v2:32'h70, t2:0, imm:0, rd:5,
          pc:32'h18, pj:0};
    cyc("sub", 1, 1, e);

    // rollback blocks lui x4,0xABCDE; it issues the next cycle
    nx();
    inst_rdy = 1; inst = 32'hABCDE237; inst_pc = 32'h1C;
    rollback = 1; rob_free_pos = 10;
    cyc("rollback", 0, 0, e);
    nx();
    inst_rdy = 1; inst = 32'hABCDE237; inst_pc = 32'h1C;
    rob_free_pos = 10;
    reg_rs1_val = 32'h1234; reg_rs1_rob_id = 5'b1_0001;
    reg_rs2_val = 32'h5678; reg_rs2_rob_id = 5'b1_0011;
    e = '{iss:1, rs:1, lsb:0, rob:10, op:7'h37, f3:6, f7:0,
          v1:0, t1:0, v2:0, t2:0, imm:32'hABCDE000, rd:4,
          pc:32'h1C, pj:0};
    cyc("lui", 1, 1, e);

    // beq x1,x2,-8: rs1 from LSB broadcast, rs2 from ROB ready value
    nx();
    inst_rdy = 1; inst = 32'hFE208CE3; inst_pc = 32'h40;
    inst_pred_jump = 1; rob_free_pos = 11;
    reg_rs1_rob_id = 5'b1_0101; reg_rs2_rob_id = 5'b1_1000;
    alu_result = 1; alu_result_rob_pos = 3; alu_result_val = 32'h33;
    lsb_result = 1; lsb_result_rob_pos = 5; lsb_result_val = 32'h55;
    rob_rs1_ready = 0; rob_rs2_ready = 1; rob_rs2_val = 32'h77;
    e = '{iss:1, rs:1, lsb:0, rob:11, op:7'h63, f3:0, f7:0,
          v1:32'h55, t1:0, v2:32'h77, t2:0, imm:32'hFFFFFFF8,
          rd:5'h19, pc:32'h40, pj:1};
    cyc("beq", 1, 1, e);

    // fence: acked and dropped
    nx();
    inst_rdy = 1; inst = 32'h0000000F; inst_pc = 32'h44;
    cyc("fence", 1, 0, e);

    nx();
    cyc("idle2", 0, 0, e);

    // rdy low: nothing consumed, strobes hold at 0
    nx();
    rdy = 0; inst_rdy = 1; inst = 32'h00500093;
    cyc("rdy_low", 0, 0, e);

    nx();
    cyc("idle3", 0, 0, e);
    nx();
    chk("queue_drained", q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
